// File: rtl/ula_pkg.sv
// Shared constants for the ALU-control decoder and the multiply/divide sequencer:
// class codes, R-type function codes, ALU operation codes and the sequencer FSM states.
// Optional divide support is selected with the ULA_DIV_EN macro.
package ula_pkg;

  // Class codes from the main control unit
  localparam logic [2:0] ClsAdd   = 3'b000;
  localparam logic [2:0] ClsSub   = 3'b001;
  localparam logic [2:0] ClsRtype = 3'b010;
  localparam logic [2:0] ClsSlti  = 3'b011;
  localparam logic [2:0] ClsAndi  = 3'b100;
  localparam logic [2:0] ClsOri   = 3'b101;
  localparam logic [2:0] ClsXori  = 3'b110;
  localparam logic [2:0] ClsLui   = 3'b111;

  // R-type function codes
  localparam logic [5:0] FnSll   = 6'b000000;
  localparam logic [5:0] FnSrl   = 6'b000010;
  localparam logic [5:0] FnSra   = 6'b000011;
  localparam logic [5:0] FnSllv  = 6'b000100;
  localparam logic [5:0] FnSrlv  = 6'b000110;
  localparam logic [5:0] FnSrav  = 6'b000111;
  localparam logic [5:0] FnJr    = 6'b001000;
  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMthi  = 6'b010001;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMtlo  = 6'b010011;
  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;
  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnXor   = 6'b100110;
  localparam logic [5:0] FnNor   = 6'b100111;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnSltu  = 6'b101011;

  // ALU operation codes
  localparam logic [3:0] OpAnd    = 4'b0000;
  localparam logic [3:0] OpOr     = 4'b0001;
  localparam logic [3:0] OpAdd    = 4'b0010;
  localparam logic [3:0] OpSll    = 4'b0011;
  localparam logic [3:0] OpSrl    = 4'b0101;
  localparam logic [3:0] OpSub    = 4'b0110;
  localparam logic [3:0] OpSlt    = 4'b0111;
  localparam logic [3:0] OpMfhi   = 4'b1000;
  localparam logic [3:0] OpMflo   = 4'b1001;
  localparam logic [3:0] OpMulDiv = 4'b1010;
  localparam logic [3:0] OpLui    = 4'b1011;
  localparam logic [3:0] OpNor    = 4'b1100;
  localparam logic [3:0] OpXor    = 4'b1101;
  localparam logic [3:0] OpSllv   = 4'b1110;
  localparam logic [3:0] OpSrlv   = 4'b1111;

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} seq_state_e;

endpackage

// File: rtl/ula_seq_control_if.sv
// EX-stage bus between main control / operand fetch and ula_seq_control.
// master = pipeline side, slave = ula_seq_control.
interface ula_seq_control_if #(
  parameter int unsigned WIDTH = 32
);
  logic [2:0]       ula_operation;
  logic [5:0]       func;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       operation;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hilo_rd;

  modport master (
    output ula_operation, func, start, a, b,
    input  operation, stall, busy, done, hi, lo, hilo_rd
  );

  modport slave (
    input  ula_operation, func, start, a, b,
    output operation, stall, busy, done, hi, lo, hilo_rd
  );
endinterface

// File: rtl/ula_muldiv_seq.sv
// Iterative radix-2 multiply/divide sequencer: shift-add multiply, restoring divide,
// sign fix-up on magnitudes. The divide datapath exists only when ULA_DIV_EN is defined.
module ula_muldiv_seq
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,   // accept request, honoured only in StIdle
  input  logic [1:0]       op,      // [1] divide, [0] unsigned
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  seq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic             neg_a_q, neg_b_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_res_q, lo_res_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] fix_hi, fix_lo;

`ifdef ULA_DIV_EN
  logic             div0_q;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
`else
  logic             unused_div;
  assign unused_div = op_q[1];
`endif

  // Operand magnitudes and signs for the request at the inputs
  always_comb begin
    a_neg = ~op[0] & a[WIDTH-1];
    b_neg = ~op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One radix-2 step: acc_hi is the partial product / partial remainder,
  // acc_lo the multiplier / dividend shifting out while quotient bits shift in
  always_comb begin
    mul_sum = {1'b0, acc_hi_q} + {1'b0, opnd_q};
    if (acc_lo_q[0]) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end else begin
      step_hi = {1'b0, acc_hi_q[WIDTH-1:1]};
      step_lo = {acc_hi_q[0], acc_lo_q[WIDTH-1:1]};
    end
`ifdef ULA_DIV_EN
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    if (op_q[1]) begin
      // Remainder stays below the divisor, so the low WIDTH bits of the difference suffice
      step_hi = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end
`endif
  end

  // Sign fix-up of the unsigned results
  always_comb begin
    prod = {acc_hi_q, acc_lo_q};
    if (neg_a_q ^ neg_b_q) prod = -prod;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
`ifdef ULA_DIV_EN
    if (div0_q) begin
      fix_hi = acc_hi_q;
      fix_lo = neg_a_q ? WIDTH'(1) : '1;
    end else if (op_q[1]) begin
      fix_hi = neg_a_q ? -acc_hi_q : acc_hi_q;
      fix_lo = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
    end
`endif
  end

  // Sequencer FSM with registered busy/done/results
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_res_q <= '0;
      lo_res_q <= '0;
`ifdef ULA_DIV_EN
      div0_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q     <= op;
            neg_a_q  <= a_neg;
            neg_b_q  <= b_neg;
            busy_q   <= 1'b1;
            cnt_q    <= CNT_W'(WIDTH);
            opnd_q   <= a_mag;
            acc_lo_q <= b_mag;
            acc_hi_q <= '0;
            state_q  <= StRun;
`ifdef ULA_DIV_EN
            div0_q <= 1'b0;
            if (op[1]) begin
              opnd_q   <= b_mag;
              acc_lo_q <= a_mag;
              if (b == '0) begin
                // Skip the iterations; FIX still runs so done lands two cycles out
                div0_q   <= 1'b1;
                acc_hi_q <= a;
                state_q  <= StFix;
              end
            end
`endif
          end
        end
        StRun: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= StFix;
        end
        StFix: begin
          hi_res_q <= fix_hi;
          lo_res_q <= fix_lo;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign hi_res = hi_res_q;
  assign lo_res = lo_res_q;

endmodule

// File: rtl/ula_seq_control.sv
// EX-stage ALU-control decoder with HI/LO registers, MT*/MF* handling and the
// pipeline stall for the multiply/divide sequencer. DIV/DIVU need ULA_DIV_EN.
module ula_seq_control
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  ula_seq_control_if.slave bus
);

  logic             is_rtype;
  logic             fn_mul, fn_div, fn_mf, fn_mthi, fn_mtlo;
  logic             seq_start, seq_busy, seq_done;
  logic [WIDTH-1:0] hi_res, lo_res;
  logic [WIDTH-1:0] hi_q, lo_q, hi_now, lo_now;
  logic [3:0]       operation;
  logic             mt_en;

  assign is_rtype = bus.ula_operation == ClsRtype;
  assign fn_mul   = (bus.func == FnMult) || (bus.func == FnMultu);
`ifdef ULA_DIV_EN
  assign fn_div   = (bus.func == FnDiv) || (bus.func == FnDivu);
`else
  assign fn_div   = 1'b0;
`endif
  assign fn_mf    = (bus.func == FnMfhi) || (bus.func == FnMflo);
  assign fn_mthi  = bus.func == FnMthi;
  assign fn_mtlo  = bus.func == FnMtlo;

  assign seq_start = bus.start & is_rtype & (fn_mul | fn_div);
  assign mt_en     = bus.start & is_rtype & ~seq_busy;

  // ALU operation decode
  always_comb begin
    operation = OpAnd;
    unique case (bus.ula_operation)
      ClsAdd:  operation = OpAdd;
      ClsSub:  operation = OpSub;
      ClsSlti: operation = OpSlt;
      ClsAndi: operation = OpAnd;
      ClsOri:  operation = OpOr;
      ClsXori: operation = OpXor;
      ClsLui:  operation = OpLui;
      ClsRtype: begin
        unique case (bus.func)
          FnAdd:                                 operation = OpAdd;
          FnSub:                                 operation = OpSub;
          FnAnd:                                 operation = OpAnd;
          FnOr:                                  operation = OpOr;
          FnXor:                                 operation = OpXor;
          FnNor:                                 operation = OpNor;
          FnSlt, FnSltu:                         operation = OpSlt;
          FnSll, FnJr:                           operation = OpSll;
          FnSrl, FnSra:                          operation = OpSrl;
          FnSllv:                                operation = OpSllv;
          FnSrlv, FnSrav:                        operation = OpSrlv;
          FnMfhi:                                operation = OpMfhi;
          FnMflo:                                operation = OpMflo;
          FnMthi, FnMtlo, FnMult, FnMultu,
          FnDiv, FnDivu:                         operation = OpMulDiv;
          default:                               operation = OpAnd;
        endcase
      end
      default: operation = OpAnd;
    endcase
  end

  ula_muldiv_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_seq (
    .clock  (clock),
    .reset  (reset),
    .start  (seq_start),
    .op     (bus.func[1:0]),
    .a      (bus.a),
    .b      (bus.b),
    .busy   (seq_busy),
    .done   (seq_done),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  // HI/LO registers: sequencer results in DONE, otherwise MTHI/MTLO when idle
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (seq_done) begin
      hi_q <= hi_res;
      lo_q <= lo_res;
    end else if (mt_en) begin
      if (fn_mthi) hi_q <= bus.a;
      if (fn_mtlo) lo_q <= bus.a;
    end
  end

  // Results become visible in the DONE cycle itself, before the register captures them
  assign hi_now = seq_done ? hi_res : hi_q;
  assign lo_now = seq_done ? lo_res : lo_q;

  assign bus.operation = operation;
  assign bus.busy      = seq_busy;
  assign bus.done      = seq_done;
  assign bus.hi        = hi_now;
  assign bus.lo        = lo_now;
  assign bus.stall     = seq_busy & bus.start & (fn_mul | fn_div | fn_mf | fn_mthi | fn_mtlo);
  assign bus.hilo_rd   = !is_rtype               ? '0     :
                         (bus.func == FnMfhi)    ? hi_now :
                         (bus.func == FnMflo)    ? lo_now : '0;

endmodule

// File: tb/tb_ula_seq_control.sv
// Directed bench for ula_seq_control (WIDTH=32): decode sweep, mul/div results and latency,
// stall behaviour, MT*/MF*, mid-run reset. DIV cases follow the ULA_DIV_EN build option.
module tb_ula_seq_control;
  import ula_pkg::*;

  localparam int unsigned W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ula_seq_control_if #(.WIDTH(W)) bus ();

  ula_seq_control #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] cls, input logic [5:0] fn,
                       input logic [31:0] av, input logic [31:0] bv);
    bus.start         = s;
    bus.ula_operation = cls;
    bus.func          = fn;
    bus.a             = av;
    bus.b             = bv;
  endtask

  // Issue one mul/div, count cycles until done, check latency and results
  task automatic muldiv(input string tag, input logic [5:0] fn, input logic [31:0] av,
                        input logic [31:0] bv, input int lat, input logic [31:0] ehi,
                        input logic [31:0] elo);
    int cyc;
    @(negedge clock);
    drive(1'b1, 3'b010, fn, av, bv);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        check({tag, "_busy1"}, bus.busy, 1);
        drive(1'b0, 3'b000, 6'b0, 32'd0, 32'd0);
      end
    end while (!bus.done && cyc < 200);
    check({tag, "_lat"}, cyc, lat);
    check({tag, "_hi"}, bus.hi, ehi);
    check({tag, "_lo"}, bus.lo, elo);
    @(negedge clock);
    check({tag, "_busy_after"}, bus.busy, 0);
    check({tag, "_done_after"}, bus.done, 0);
    check({tag, "_hi_held"}, bus.hi, ehi);
    check({tag, "_lo_held"}, bus.lo, elo);
  endtask

  typedef struct packed {
    logic [2:0] cls;
    logic [5:0] fn;
    logic [3:0] op;
  } dec_t;

  dec_t tbl [31] = '{
    {3'b010, 6'b100000, 4'b0010}, {3'b010, 6'b100010, 4'b0110},
    {3'b010, 6'b100100, 4'b0000}, {3'b010, 6'b100101, 4'b0001},
    {3'b010, 6'b100110, 4'b1101}, {3'b010, 6'b100111, 4'b1100},
    {3'b010, 6'b101010, 4'b0111}, {3'b010, 6'b101011, 4'b0111},
    {3'b010, 6'b000000, 4'b0011}, {3'b010, 6'b001000, 4'b0011},
    {3'b010, 6'b000010, 4'b0101}, {3'b010, 6'b000011, 4'b0101},
    {3'b010, 6'b000100, 4'b1110}, {3'b010, 6'b000110, 4'b1111},
    {3'b010, 6'b000111, 4'b1111}, {3'b010, 6'b010000, 4'b1000},
    {3'b010, 6'b010010, 4'b1001}, {3'b010, 6'b010001, 4'b1010},
    {3'b010, 6'b010011, 4'b1010}, {3'b010, 6'b011000, 4'b1010},
    {3'b010, 6'b011001, 4'b1010}, {3'b010, 6'b011010, 4'b1010},
    {3'b010, 6'b011011, 4'b1010}, {3'b010, 6'b111111, 4'b0000},
    {3'b000, 6'b000000, 4'b0010}, {3'b001, 6'b000000, 4'b0110},
    {3'b011, 6'b000000, 4'b0111}, {3'b100, 6'b000000, 4'b0000},
    {3'b101, 6'b000000, 4'b0001}, {3'b110, 6'b000000, 4'b1101},
    {3'b111, 6'b000000, 4'b1011}
  };

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n_done;

    // Reset state
    drive(1'b0, 3'b010, 6'b010000, 32'd0, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_hilo_rd", bus.hilo_rd, 0);
    reset = 1'b0;

    // Decode sweep
    for (int i = 0; i < 31; i++) begin
      @(negedge clock);
      drive(1'b0, tbl[i].cls, tbl[i].fn, 32'h55, 32'h66);
      #1;
      check($sformatf("dec_%0d_op", i), bus.operation, tbl[i].op);
      check($sformatf("dec_%0d_stall", i), bus.stall, 0);
    end

    // Multiply
    muldiv("mult_m3x7", 6'b011000, 32'hFFFF_FFFD, 32'd7, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    muldiv("multu_max_x2", 6'b011001, 32'hFFFF_FFFF, 32'd2, 34, 32'd1, 32'hFFFF_FFFE);
    muldiv("mult_m4xm5", 6'b011000, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 34, 32'd0, 32'd20);

`ifdef ULA_DIV_EN
    muldiv("div_m7d2", 6'b011010, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    muldiv("divu_7d0", 6'b011011, 32'd7, 32'd0, 2, 32'd7, 32'hFFFF_FFFF);
    muldiv("div_m5d0", 6'b011010, 32'hFFFF_FFFB, 32'd0, 2, 32'hFFFF_FFFB, 32'd1);
    muldiv("div_ovf", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000);
    muldiv("divu_100d7", 6'b011011, 32'd100, 32'd7, 34, 32'd2, 32'd14);
`endif

    // Stall behaviour: add proceeds mid-run, MFLO held until the sequencer is idle
    @(negedge clock);
    drive(1'b1, 3'b010, 6'b011000, 32'd5, 32'd6);
    for (cyc = 1; cyc <= 35; cyc++) begin
      @(negedge clock);
      if (cyc == 1) drive(1'b0, 3'b000, 6'b0, 32'd0, 32'd0);
      if (cyc == 3) begin
        drive(1'b1, 3'b010, 6'b100000, 32'd1, 32'd2);
        #1;
        check("add_mid_stall", bus.stall, 0);
        check("add_mid_op", bus.operation, 4'b0010);
      end
      if (cyc == 4) drive(1'b0, 3'b000, 6'b0, 32'd0, 32'd0);
      if (cyc == 5) drive(1'b1, 3'b010, 6'b010010, 32'd0, 32'd0);
      if (cyc >= 5 && cyc <= 34) begin
        #1;
        check($sformatf("mflo_stall_c%0d", cyc), bus.stall, 1);
      end
      if (cyc == 34) check("mflo_run_done", bus.done, 1);
      if (cyc == 35) begin
        #1;
        check("mflo_release_stall", bus.stall, 0);
        check("mflo_rd", bus.hilo_rd, 32'd30);
        check("mflo_done_low", bus.done, 0);
      end
    end

    // MTHI/MTLO then MFHI/MFLO
    @(negedge clock);
    drive(1'b1, 3'b010, 6'b010001, 32'd1234, 32'd0);
    @(negedge clock);
    drive(1'b1, 3'b010, 6'b010000, 32'd0, 32'd0);
    #1;
    check("mthi_hi", bus.hi, 32'd1234);
    check("mfhi_rd", bus.hilo_rd, 32'd1234);
    check("mfhi_stall", bus.stall, 0);
    @(negedge clock);
    drive(1'b1, 3'b010, 6'b010011, 32'h0000_ABCD, 32'd0);
    @(negedge clock);
    drive(1'b1, 3'b010, 6'b010010, 32'd0, 32'd0);
    #1;
    check("mtlo_lo", bus.lo, 32'h0000_ABCD);
    check("mflo_rd2", bus.hilo_rd, 32'h0000_ABCD);
    check("mtlo_hi_kept", bus.hi, 32'd1234);

    // Reset in the middle of a run
    @(negedge clock);
`ifdef ULA_DIV_EN
    drive(1'b1, 3'b010, 6'b011011, 32'd100, 32'd7);
`else
    drive(1'b1, 3'b010, 6'b011000, 32'd5, 32'd6);
`endif
    n_done = 0;
    for (cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clock);
      if (cyc == 1) drive(1'b0, 3'b000, 6'b0, 32'd0, 32'd0);
      if (cyc == 10) begin
        check("pre_rst_busy", bus.busy, 1);
        reset = 1'b1;
      end
      if (cyc == 11) begin
        check("midrst_busy", bus.busy, 0);
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);
        check("midrst_done", bus.done, 0);
        reset = 1'b0;
      end
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.done) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    check("midrst_idle", bus.busy, 0);

`ifndef ULA_DIV_EN
    // DIV ignored in a build without the divider
    @(negedge clock);
    drive(1'b1, 3'b010, 6'b010001, 32'h11, 32'd0);
    @(negedge clock);
    drive(1'b1, 3'b010, 6'b010011, 32'h22, 32'd0);
    @(negedge clock);
    drive(1'b1, 3'b010, 6'b011010, 32'd100, 32'd7);
    #1;
    check("nodiv_op", bus.operation, 4'b1010);
    check("nodiv_stall", bus.stall, 0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (i == 1) drive(1'b0, 3'b000, 6'b0, 32'd0, 32'd0);
      if (bus.busy || bus.done) n_done++;
    end
    check("nodiv_never_busy", n_done, 0);
    check("nodiv_hi", bus.hi, 32'h11);
    check("nodiv_lo", bus.lo, 32'h22);
`endif

    // Multiply still completes after the above
    muldiv("mult_final", 6'b011000, 32'd9, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
